// File: rtl/demux1_4_reg_if.sv
// Beat input and lane output bundle for demux1_4_reg.
interface demux1_4_reg_if #(parameter int WIDTH = 1);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       s;
  logic             auto;
  logic [WIDTH-1:0] out_a, out_b, out_c, out_d;
  logic             valid_a, valid_b, valid_c, valid_d;
  logic             frame_done;
  logic [1:0]       lane_ptr;

  modport master (
    output in_valid, in_data, s, auto,
    input  out_a, out_b, out_c, out_d,
    input  valid_a, valid_b, valid_c, valid_d, frame_done, lane_ptr
  );

  modport slave (
    input  in_valid, in_data, s, auto,
    output out_a, out_b, out_c, out_d,
    output valid_a, valid_b, valid_c, valid_d, frame_done, lane_ptr
  );
endinterface

// File: rtl/demux1_4_reg.sv
// Registered 1-to-4 demux: fixed select or round-robin lane steering,
// with per-lane write strobes and a frame-done strobe on the lane-d auto write.
module demux1_4_lane #(parameter int WIDTH = 1) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             vld
);
  always_ff @(posedge clk) begin
    if (reset) begin
      q   <= '0;
      vld <= 1'b0;
    end else begin
      vld <= we;
      if (we) q <= d;
    end
  end
endmodule

module demux1_4_reg #(parameter int WIDTH = 1) (
  input logic          clk,
  input logic          reset,
  demux1_4_reg_if.slave bus
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {LANE_A = 2'd0, LANE_B = 2'd1, LANE_C = 2'd2, LANE_D = 2'd3} ptr_t;

  ptr_t                               ptr, ptr_nxt;
  logic [1:0]                         tgt;
  logic [NUM_LANES-1:0]               we;
  logic [NUM_LANES-1:0][WIDTH-1:0]    lane_q;
  logic [NUM_LANES-1:0]               lane_vld;
  logic                               fd_q, fd_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr  <= LANE_A;
      fd_q <= 1'b0;
    end else begin
      ptr  <= ptr_nxt;
      fd_q <= fd_nxt;
    end
  end

  // Fixed mode pins the pointer to lane a so each auto run starts fresh.
  always_comb begin
    ptr_nxt = ptr;
    tgt     = bus.s;
    we      = '0;
    fd_nxt  = 1'b0;
    if (bus.auto) begin
      tgt = ptr;
      if (bus.in_valid) begin
        ptr_nxt = ptr_t'(ptr + 2'd1);
        fd_nxt  = (ptr == LANE_D);
      end
    end else begin
      ptr_nxt = LANE_A;
    end
    if (bus.in_valid) we[tgt] = 1'b1;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    demux1_4_lane #(.WIDTH(WIDTH)) u_lane (
      .clk   (clk),
      .reset (reset),
      .we    (we[i]),
      .d     (bus.in_data),
      .q     (lane_q[i]),
      .vld   (lane_vld[i])
    );
  end

  assign bus.out_a      = lane_q[0];
  assign bus.out_b      = lane_q[1];
  assign bus.out_c      = lane_q[2];
  assign bus.out_d      = lane_q[3];
  assign bus.valid_a    = lane_vld[0];
  assign bus.valid_b    = lane_vld[1];
  assign bus.valid_c    = lane_vld[2];
  assign bus.valid_d    = lane_vld[3];
  assign bus.frame_done = fd_q;
  assign bus.lane_ptr   = ptr;
endmodule

// File: tb/tb_demux1_4_reg.sv
// Bench for demux1_4_reg: directed table, corner sequences, and random beats vs a lane/beat-count model.
module tb_demux1_4_reg;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  demux1_4_reg_if #(.WIDTH(W)) bus();
  demux1_4_reg #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  // Model: lane contents plus number of beats since auto run began.
  logic [W-1:0] m_lane [4];
  logic [3:0]   m_vld;
  logic         m_fd;
  int           m_cnt;
  int           fd_seen;

  typedef struct {
    logic rst, iv, au;
    logic [1:0] s;
    logic [W-1:0] d;
    logic [31:0] e_out;
    logic [3:0]  e_vld;
    logic        e_fd;
    logic [1:0]  e_ptr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_out();
    return {bus.out_d, bus.out_c, bus.out_b, bus.out_a};
  endfunction
  function automatic logic [3:0] dut_vld();
    return {bus.valid_d, bus.valid_c, bus.valid_b, bus.valid_a};
  endfunction

  task automatic model_edge(input logic rst, iv, au, input logic [1:0] s, input logic [W-1:0] d);
    int tgt;
    m_vld = '0;
    m_fd  = 1'b0;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_lane[i] = '0;
      m_cnt = 0;
    end else begin
      tgt = au ? (m_cnt % 4) : int'(s);
      if (iv) begin
        m_lane[tgt] = d;
        m_vld[tgt]  = 1'b1;
        if (au && tgt == 3) m_fd = 1'b1;
        if (au) m_cnt++;
      end
      if (!au) m_cnt = 0;
    end
  endtask

  task automatic step(input logic rst, iv, au, input logic [1:0] s, input logic [W-1:0] d);
    @(negedge clk);
    reset = rst; bus.in_valid = iv; bus.auto = au; bus.s = s; bus.in_data = d;
    @(posedge clk);
    #1;
    model_edge(rst, iv, au, s, d);
    if (bus.frame_done) fd_seen++;
    chk("model_out", dut_out(), {m_lane[3], m_lane[2], m_lane[1], m_lane[0]});
    chk("model_vld", {28'd0, dut_vld()}, {28'd0, m_vld});
    chk("model_fd", {31'd0, bus.frame_done}, {31'd0, m_fd});
    chk("model_ptr", {30'd0, bus.lane_ptr}, 32'(m_cnt % 4));
  endtask

  vec_t tbl [11];

  initial begin
    reset = 1'b1; bus.in_valid = 1'b0; bus.auto = 1'b0; bus.s = 2'd0; bus.in_data = '0;
    for (int i = 0; i < 4; i++) m_lane[i] = '0;
    m_cnt = 0; fd_seen = 0;

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 2'd0, 8'd1, 32'h00000000, 4'b0000, 1'b0, 2'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 2'd0, 8'd1, 32'h00000000, 4'b0000, 1'b0, 2'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 2'd1, 8'd1, 32'h00000100, 4'b0010, 1'b0, 2'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 2'd1, 8'd1, 32'h00000100, 4'b0000, 1'b0, 2'd0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 2'd3, 8'd1, 32'h01000100, 4'b1000, 1'b0, 2'd0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 32'h00000000, 4'b0000, 1'b0, 2'd0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 2'd2, 8'd1, 32'h00000001, 4'b0001, 1'b0, 2'd1};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 2'd3, 8'd0, 32'h00000001, 4'b0010, 1'b0, 2'd2};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 2'd0, 8'd1, 32'h00010001, 4'b0100, 1'b0, 2'd3};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 2'd1, 8'd1, 32'h01010001, 4'b1000, 1'b1, 2'd0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 2'd2, 8'd0, 32'h01010000, 4'b0001, 1'b0, 2'd1};

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].rst, tbl[i].iv, tbl[i].au, tbl[i].s, tbl[i].d);
      chk($sformatf("tbl%0d_out", i), dut_out(), tbl[i].e_out);
      chk($sformatf("tbl%0d_vld", i), {28'd0, dut_vld()}, {28'd0, tbl[i].e_vld});
      chk($sformatf("tbl%0d_fd", i), {31'd0, bus.frame_done}, {31'd0, tbl[i].e_fd});
      chk($sformatf("tbl%0d_ptr", i), {30'd0, bus.lane_ptr}, {30'd0, tbl[i].e_ptr});
    end

    // Gap: pointer holds through idle cycles, frame_done once.
    step(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    fd_seen = 0;
    step(1'b0, 1'b1, 1'b1, 2'd0, 8'd5);
    step(1'b0, 1'b1, 1'b1, 2'd0, 8'd6);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 2'd0, 8'hee);
      chk("gap_ptr", {30'd0, bus.lane_ptr}, 32'd2);
    end
    step(1'b0, 1'b1, 1'b1, 2'd0, 8'd7);
    chk("gap_c", {24'd0, bus.out_c}, 32'd7);
    step(1'b0, 1'b1, 1'b1, 2'd0, 8'd8);
    chk("gap_d", {24'd0, bus.out_d}, 32'd8);
    chk("gap_fd_count", 32'(fd_seen), 32'd1);

    // Reset mid-frame.
    step(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    step(1'b0, 1'b1, 1'b1, 2'd0, 8'd1);
    step(1'b0, 1'b1, 1'b1, 2'd0, 8'd1);
    step(1'b1, 1'b0, 1'b1, 2'd0, 8'd0);
    step(1'b0, 1'b1, 1'b1, 2'd0, 8'd1);
    chk("rst_mid_a", {24'd0, bus.out_a}, 32'd1);
    chk("rst_mid_b", {24'd0, bus.out_b}, 32'd0);
    chk("rst_mid_ptr", {30'd0, bus.lane_ptr}, 32'd1);

    // Mode switch mid-run: fixed beat to c, next auto beat back to a.
    step(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    fd_seen = 0;
    step(1'b0, 1'b1, 1'b1, 2'd0, 8'd1);
    step(1'b0, 1'b1, 1'b1, 2'd0, 8'd2);
    step(1'b0, 1'b1, 1'b1, 2'd0, 8'd3);
    step(1'b0, 1'b1, 1'b0, 2'd2, 8'd9);
    chk("sw_fixed_c", {24'd0, bus.out_c}, 32'd9);
    chk("sw_fixed_vld", {28'd0, dut_vld()}, 32'b0100);
    chk("sw_fixed_ptr", {30'd0, bus.lane_ptr}, 32'd0);
    step(1'b0, 1'b1, 1'b1, 2'd3, 8'd4);
    chk("sw_auto_a", {24'd0, bus.out_a}, 32'd4);
    chk("sw_auto_vld", {28'd0, dut_vld()}, 32'b0001);
    chk("sw_fd_none", 32'(fd_seen), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
